// File: rtl/raster_pkg.sv
// Shared types and constants for the raster frame sequencer.
// Holds the FSM state encoding, pixel field widths and default resolution.
package raster_pkg;

    localparam int COLOR_W   = 3;
    localparam int COORD_W   = 10;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DRAW,
        ST_WAIT_VS
    } rfs_state_e;

    function automatic coord_t to_coord(input int v);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/raster_frame_sequencer_if.sv
// Pixel-write path: line-generator request side and frame-buffer write side.
// master = sequencer, slave = line generator plus frame buffer.
interface raster_frame_sequencer_if;
    import raster_pkg::*;

    logic   lg_wr_req;
    coord_t lg_x;
    coord_t lg_y;
    color_t lg_color;
    logic   lg_wr_ack;
    logic   lg_enable;

    logic   fb_wr_en;
    coord_t fb_x;
    coord_t fb_y;
    color_t fb_color;
    logic   fb_ready;

    modport master (
        input  lg_wr_req, lg_x, lg_y, lg_color, fb_ready,
        output lg_wr_ack, lg_enable, fb_wr_en, fb_x, fb_y, fb_color
    );

    modport slave (
        output lg_wr_req, lg_x, lg_y, lg_color, fb_ready,
        input  lg_wr_ack, lg_enable, fb_wr_en, fb_x, fb_y, fb_color
    );

endinterface

// File: rtl/rfs_clear_counter.sv
// Raster-order x/y scan counter used to sweep the screen during clear.
// Advances one pixel per enabled cycle; wrap is high while sitting on the last pixel.
module rfs_clear_counter
    import raster_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    output coord_t x,
    output coord_t y,
    output logic   wrap
);

    localparam coord_t X_LAST = coord_t'(H_RES - 1);
    localparam coord_t Y_LAST = coord_t'(V_RES - 1);

    coord_t x_q, x_d;
    coord_t y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign wrap = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/raster_frame_sequencer.sv
// Frame sequencer: clear to bk_color, forward line-generator pixels, swap buffers on vsync.
// Zero-latency write path; fb_ready stalls clear and holds lg requests unacked.
// RFS_CLIP_EN: drop (ack without writing) off-screen line-generator pixels.
module raster_frame_sequencer
    import raster_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  color_t                      bk_color,
    input  logic                        raster_done,
    input  logic                        vsync,
    raster_frame_sequencer_if.master    px,
    output logic                        buf_sel,
    output logic                        frame_done,
    output logic                        busy
);

`ifdef RFS_CLIP_EN
    localparam coord_t H_LIM = coord_t'(H_RES);
    localparam coord_t V_LIM = coord_t'(V_RES);
`endif

    rfs_state_e state_q, state_d;
    logic       pending_q, pending_d;
    logic       buf_sel_q, buf_sel_d;
    logic       frame_done_q, frame_done_d;

    logic       cnt_en;
    logic       cnt_clr;
    coord_t     cnt_x;
    coord_t     cnt_y;
    logic       cnt_wrap;

    rfs_clear_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clear_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .x    (cnt_x),
        .y    (cnt_y),
        .wrap (cnt_wrap)
    );

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        buf_sel_d    = buf_sel_q;
        frame_done_d = 1'b0;
        cnt_en       = 1'b0;
        cnt_clr      = 1'b0;
        px.lg_wr_ack = 1'b0;
        px.lg_enable = 1'b0;
        px.fb_wr_en  = 1'b0;
        px.fb_x      = '0;
        px.fb_y      = '0;
        px.fb_color  = '0;

        // A request arriving mid-frame is remembered once and replayed from IDLE.
        if (state_q != ST_IDLE && frame_start) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start || pending_q) begin
                    state_d   = ST_CLEAR;
                    cnt_clr   = 1'b1;
                    pending_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                px.fb_wr_en = 1'b1;
                px.fb_x     = cnt_x;
                px.fb_y     = cnt_y;
                px.fb_color = bk_color;
                cnt_en      = px.fb_ready;
                if (px.fb_ready && cnt_wrap) begin
                    state_d = ST_DRAW;
                end
            end

            ST_DRAW: begin
                px.lg_enable = 1'b1;
                px.fb_x      = px.lg_x;
                px.fb_y      = px.lg_y;
                px.fb_color  = px.lg_color;
`ifdef RFS_CLIP_EN
                if ((px.lg_x >= H_LIM) || (px.lg_y >= V_LIM)) begin
                    px.fb_wr_en  = 1'b0;
                    px.lg_wr_ack = px.lg_wr_req;
                end else begin
                    px.fb_wr_en  = px.lg_wr_req;
                    px.lg_wr_ack = px.lg_wr_req & px.fb_ready;
                end
`else
                px.fb_wr_en  = px.lg_wr_req;
                px.lg_wr_ack = px.lg_wr_req & px.fb_ready;
`endif
                // Never leave with a pixel still in flight.
                if (raster_done && !px.lg_wr_req) begin
                    state_d = ST_WAIT_VS;
                end
            end

            ST_WAIT_VS: begin
                if (vsync) begin
                    buf_sel_d    = ~buf_sel_q;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            buf_sel_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            buf_sel_q    <= buf_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign buf_sel    = buf_sel_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// Directed bench for raster_frame_sequencer at H_RES=4, V_RES=3.
module tb_raster_frame_sequencer;
    import raster_pkg::*;

    logic   clk;
    logic   rst;
    logic   frame_start;
    color_t bk_color;
    logic   raster_done;
    logic   vsync;
    logic   buf_sel;
    logic   frame_done;
    logic   busy;

    int total;
    int bad;

    raster_frame_sequencer_if rif();

    raster_frame_sequencer #(
        .H_RES (4),
        .V_RES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bk_color    (bk_color),
        .raster_done (raster_done),
        .vsync       (vsync),
        .px          (rif),
        .buf_sel     (buf_sel),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; frame_start = 1'b0; bk_color = '0; raster_done = 1'b0; vsync = 1'b0;
        rif.lg_wr_req = 1'b0; rif.lg_x = '0; rif.lg_y = '0; rif.lg_color = '0; rif.fb_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
        total++; if (rif.fb_wr_en !== 1'b0) begin bad++; $display("FAIL reset_fb_wr_en got=%b want=0", rif.fb_wr_en); end
        total++; if (rif.lg_enable !== 1'b0) begin bad++; $display("FAIL reset_lg_enable got=%b want=0", rif.lg_enable); end
        total++; if (rif.lg_wr_ack !== 1'b0) begin bad++; $display("FAIL reset_lg_wr_ack got=%b want=0", rif.lg_wr_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (buf_sel !== 1'b0) begin bad++; $display("FAIL reset_buf_sel got=%b want=0", buf_sel); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if ({rif.fb_x, rif.fb_y, rif.fb_color} !== 23'd0) begin bad++;
            $display("FAIL reset_fb_bus got=%0d/%0d/%0d want=0/0/0", rif.fb_x, rif.fb_y, rif.fb_color); end
    endtask

    task automatic test_clear_full;
        bk_color = 3'b101; rif.fb_ready = 1'b1;
        rif.lg_wr_req = 1'b1; rif.lg_x = 10'd1; rif.lg_y = 10'd1; rif.lg_color = 3'b111;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++; if (rif.fb_wr_en !== 1'b1) begin bad++; $display("FAIL clear_wr_en i=%0d got=%b want=1", i, rif.fb_wr_en); end
            total++; if (rif.fb_x !== to_coord(i % 4) || rif.fb_y !== to_coord(i / 4)) begin bad++;
                $display("FAIL clear_xy i=%0d got=(%0d,%0d) want=(%0d,%0d)", i, rif.fb_x, rif.fb_y, i % 4, i / 4); end
            total++; if (rif.fb_color !== 3'b101) begin bad++; $display("FAIL clear_color i=%0d got=%b want=101", i, rif.fb_color); end
            total++; if (rif.lg_wr_ack !== 1'b0 || rif.lg_enable !== 1'b0) begin bad++;
                $display("FAIL clear_lg_quiet i=%0d got ack=%b en=%b want 0/0", i, rif.lg_wr_ack, rif.lg_enable); end
            tick;
        end
        rif.lg_wr_req = 1'b0;
        #1;
        total++; if (rif.lg_enable !== 1'b1) begin bad++; $display("FAIL clear_to_draw lg_enable got=%b want=1", rif.lg_enable); end
        total++; if (rif.fb_wr_en !== 1'b0) begin bad++; $display("FAIL draw_idle_wr_en got=%b want=0", rif.fb_wr_en); end
    endtask

    task automatic test_draw_stall;
        rif.lg_wr_req = 1'b1; rif.lg_x = 10'd2; rif.lg_y = 10'd1; rif.lg_color = 3'b011;
        rif.fb_ready = 1'b0; vsync = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (rif.fb_wr_en !== 1'b1 || rif.lg_wr_ack !== 1'b0) begin bad++;
                $display("FAIL stall k=%0d got wr_en=%b ack=%b want 1/0", k, rif.fb_wr_en, rif.lg_wr_ack); end
            total++; if (rif.fb_x !== 10'd2 || rif.fb_y !== 10'd1 || rif.fb_color !== 3'b011) begin bad++;
                $display("FAIL stall_pix k=%0d got=(%0d,%0d,%0d) want=(2,1,3)", k, rif.fb_x, rif.fb_y, rif.fb_color); end
            tick;
        end
        vsync = 1'b0;
        rif.fb_ready = 1'b1;
        #1;
        total++; if (rif.fb_wr_en !== 1'b1 || rif.lg_wr_ack !== 1'b1) begin bad++;
            $display("FAIL stall_release got wr_en=%b ack=%b want 1/1", rif.fb_wr_en, rif.lg_wr_ack); end
        total++; if (rif.lg_enable !== 1'b1) begin bad++; $display("FAIL vsync_in_draw lg_enable got=%b want=1", rif.lg_enable); end
        tick;
        rif.lg_wr_req = 1'b0;
    endtask

    task automatic test_clip;
        rif.lg_wr_req = 1'b1; rif.lg_x = 10'd4; rif.lg_y = 10'd0; rif.lg_color = 3'b110; rif.fb_ready = 1'b0;
        #1;
`ifdef RFS_CLIP_EN
        total++; if (rif.lg_wr_ack !== 1'b1 || rif.fb_wr_en !== 1'b0) begin bad++;
            $display("FAIL clip_stalled got ack=%b wr_en=%b want 1/0", rif.lg_wr_ack, rif.fb_wr_en); end
`else
        total++; if (rif.lg_wr_ack !== 1'b0 || rif.fb_wr_en !== 1'b1 || rif.fb_x !== 10'd4) begin bad++;
            $display("FAIL noclip_stalled got ack=%b wr_en=%b x=%0d want 0/1/4", rif.lg_wr_ack, rif.fb_wr_en, rif.fb_x); end
`endif
        rif.fb_ready = 1'b1;
        #1;
`ifdef RFS_CLIP_EN
        total++; if (rif.lg_wr_ack !== 1'b1 || rif.fb_wr_en !== 1'b0) begin bad++;
            $display("FAIL clip_ready got ack=%b wr_en=%b want 1/0", rif.lg_wr_ack, rif.fb_wr_en); end
`else
        total++; if (rif.lg_wr_ack !== 1'b1 || rif.fb_wr_en !== 1'b1 || rif.fb_x !== 10'd4) begin bad++;
            $display("FAIL noclip_ready got ack=%b wr_en=%b x=%0d want 1/1/4", rif.lg_wr_ack, rif.fb_wr_en, rif.fb_x); end
`endif
        tick;
        rif.lg_wr_req = 1'b0;
    endtask

    task automatic test_done_hold;
        rif.lg_wr_req = 1'b1; rif.lg_x = 10'd1; rif.lg_y = 10'd1; rif.fb_ready = 1'b0; raster_done = 1'b1;
        tick;
        #1;
        total++; if (rif.lg_enable !== 1'b1) begin bad++; $display("FAIL done_with_req lg_enable got=%b want=1", rif.lg_enable); end
        rif.lg_wr_req = 1'b0; frame_start = 1'b1;
        tick;
        raster_done = 1'b0; frame_start = 1'b0;
        #1;
        total++; if (rif.lg_enable !== 1'b0 || rif.fb_wr_en !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL wait_vs_outputs got en=%b wr_en=%b busy=%b want 0/0/1", rif.lg_enable, rif.fb_wr_en, busy); end
    endtask

    task automatic test_vsync;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (busy !== 1'b1 || buf_sel !== 1'b0 || frame_done !== 1'b0) begin bad++;
                $display("FAIL wait_vs_hold k=%0d got busy=%b sel=%b done=%b want 1/0/0", k, busy, buf_sel, frame_done); end
            tick;
        end
        vsync = 1'b1;
        tick;
        vsync = 1'b0;
        #1;
        total++; if (buf_sel !== 1'b1 || frame_done !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL swap got sel=%b done=%b busy=%b want 1/1/0", buf_sel, frame_done, busy); end
        tick;
        #1;
        total++; if (frame_done !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL pending_restart got done=%b busy=%b want 0/1", frame_done, busy); end
        total++; if (rif.fb_wr_en !== 1'b1 || rif.fb_x !== 10'd0 || rif.fb_y !== 10'd0) begin bad++;
            $display("FAIL pending_clear_origin got wr_en=%b (%0d,%0d) want 1 (0,0)", rif.fb_wr_en, rif.fb_x, rif.fb_y); end
    endtask

    task automatic test_ready_toggle;
        logic [3:0] pat;
        int idx;
        int c;
        pat = 4'b1001; idx = 0; c = 0;
        while (idx < 12 && c < 100) begin
            rif.fb_ready = pat[c[1:0]];
            frame_start = (c == 2 || c == 5);
            #1;
            total++; if (rif.fb_wr_en !== 1'b1) begin bad++; $display("FAIL toggle_wr_en c=%0d got=%b want=1", c, rif.fb_wr_en); end
            total++; if (rif.fb_x !== to_coord(idx % 4) || rif.fb_y !== to_coord(idx / 4)) begin bad++;
                $display("FAIL toggle_xy c=%0d got=(%0d,%0d) want=(%0d,%0d)", c, rif.fb_x, rif.fb_y, idx % 4, idx / 4); end
            if (rif.fb_ready) idx++;
            c++;
            tick;
        end
        frame_start = 1'b0;
        total++; if (idx !== 12) begin bad++; $display("FAIL toggle_budget got=%0d want=12", idx); end
        #1;
        total++; if (rif.lg_enable !== 1'b1) begin bad++; $display("FAIL toggle_to_draw lg_enable got=%b want=1", rif.lg_enable); end
    endtask

    task automatic test_back_to_back;
        rif.fb_ready = 1'b1; raster_done = 1'b1;
        tick;
        raster_done = 1'b0;
        #1;
        total++; if (rif.lg_enable !== 1'b0) begin bad++; $display("FAIL b2b_wait_vs lg_enable got=%b want=0", rif.lg_enable); end
        vsync = 1'b1;
        tick;
        vsync = 1'b0;
        #1;
        total++; if (buf_sel !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL b2b_swap got sel=%b done=%b busy=%b want 0/1/0", buf_sel, frame_done, busy); end
        tick;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++; if (rif.fb_wr_en !== 1'b1 || rif.fb_x !== to_coord(i % 4) || rif.fb_y !== to_coord(i / 4)) begin bad++;
                $display("FAIL b2b_clear i=%0d got wr_en=%b (%0d,%0d) want 1 (%0d,%0d)", i, rif.fb_wr_en, rif.fb_x, rif.fb_y, i % 4, i / 4); end
            tick;
        end
        raster_done = 1'b1;
        tick;
        raster_done = 1'b0; vsync = 1'b1;
        tick;
        vsync = 1'b0;
        #1;
        total++; if (buf_sel !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL b2b_second_swap got sel=%b busy=%b want 1/0", buf_sel, busy); end
        tick;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_collapse busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_clear;
        rif.fb_ready = 1'b1; frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
        end
        rst = 1'b1;
        #1;
        total++; if (rif.fb_x !== 10'd2 || rif.fb_y !== 10'd1) begin bad++;
            $display("FAIL rst_write6_xy got=(%0d,%0d) want=(2,1)", rif.fb_x, rif.fb_y); end
        tick;
        rst = 1'b0;
        #1;
        total++; if (rif.fb_wr_en !== 1'b0 || busy !== 1'b0 || buf_sel !== 1'b0) begin bad++;
            $display("FAIL rst_mid_clear got wr_en=%b busy=%b sel=%b want 0/0/0", rif.fb_wr_en, busy, buf_sel); end
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        #1;
        total++; if (rif.fb_wr_en !== 1'b1 || rif.fb_x !== 10'd0 || rif.fb_y !== 10'd0 || busy !== 1'b1) begin bad++;
            $display("FAIL rst_restart got wr_en=%b (%0d,%0d) busy=%b want 1 (0,0) 1", rif.fb_wr_en, rif.fb_x, rif.fb_y, busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset;
        test_clear_full;
        test_draw_stall;
        test_clip;
        test_done_hold;
        test_vsync;
        test_ready_toggle;
        test_back_to_back;
        test_reset_mid_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/raster_frame_sequencer.md
RASTER_FRAME_SEQUENCER -- requirements
Module: raster_frame_sequencer

Interface
REQ-001 Parameter H_RES, default 640, horizontal resolution in pixels.
REQ-002 Parameter V_RES, default 480, vertical resolution in pixels.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 frame_start  in  1  one-cycle request to begin a new frame.
REQ-006 bk_color  in  3  background colour used for screen clear.
REQ-007 raster_done  in  1  line generator has exhausted all objects for the frame.
REQ-008 vsync  in  1  one-cycle display vertical-blank pulse.
REQ-009 lg_wr_req / lg_x / lg_y / lg_color  in  1/10/10/3  pixel write request from the line generator.
REQ-010 lg_wr_ack  out  1  line-generator pixel consumed this cycle.
REQ-011 lg_enable  out  1  line generator permitted to pop its line FIFO.
REQ-012 fb_wr_en / fb_x / fb_y / fb_color  out  1/10/10/3  frame-buffer write valid, coordinates and colour.
REQ-013 fb_ready  in  1  frame buffer accepts the write this cycle; a write occurs only when fb_wr_en and fb_ready are both high.
REQ-014 buf_sel  out  1  buffer being drawn; display scans the other.
REQ-015 frame_done  out  1  one-cycle pulse on buffer swap.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, CLEAR, DRAW, WAIT_VS.
REQ-018 IDLE: outputs quiet; frame_start or pending flag set -> CLEAR next cycle, clear x=y=0, pending cleared.
REQ-019 CLEAR: fb_wr_en=1, fb_x/fb_y = counter, fb_color=bk_color, lg_enable=0, lg_wr_ack=0; counter advances only on fb_ready.
REQ-020 Counter: x increments to H_RES-1 then wraps to 0 and y increments; accepted write at (H_RES-1, V_RES-1) -> DRAW; exactly H_RES*V_RES writes per clear.
REQ-021 fb_ready low in CLEAR: counter, fb_x, fb_y held; fb_wr_en stays high.
REQ-022 DRAW: lg_enable=1; fb_wr_en=lg_wr_req; fb_x/fb_y/fb_color = lg_x/lg_y/lg_color combinationally; lg_wr_ack=lg_wr_req & fb_ready.
REQ-023 DRAW -> WAIT_VS on raster_done only when lg_wr_req is low that cycle; raster_done with lg_wr_req high is ignored until the request clears.
REQ-024 WAIT_VS: lg_enable=0, fb_wr_en=0; on vsync -> buf_sel toggles, frame_done=1 for one cycle, -> IDLE.
REQ-025 frame_start in CLEAR, DRAW or WAIT_VS sets the pending flag (one deep; repeats collapse); frame_start in IDLE coincident with pending -> single frame.
REQ-026 vsync outside WAIT_VS has no effect; raster_done outside DRAW has no effect.
REQ-027 fb_wr_en never depends combinationally on fb_ready; lg_wr_ack never high outside DRAW.

Reset
REQ-028 rst high at a clock edge: state IDLE, counter 0, pending 0, buf_sel 0, frame_done 0, fb_wr_en 0, lg_enable 0, lg_wr_ack 0, busy 0; fb_x/fb_y/fb_color 0.
REQ-029 rst mid-CLEAR or mid-DRAW abandons the frame with no further write in the following cycle; buf_sel returns to 0.

Configuration
REQ-030 Macro RFS_CLIP_EN defined: DRAW requests with lg_x>=H_RES or lg_y>=V_RES give fb_wr_en=0 and lg_wr_ack=1 in the same cycle (dropped, never stalled).
REQ-031 RFS_CLIP_EN undefined: every DRAW request is forwarded per REQ-022 regardless of coordinates.

Structure
REQ-032 Shared package raster_pkg holds the state enum, COLOR_W=3, COORD_W=10, and default H_RES/V_RES constants.
REQ-033 The clear x/y wrap counter is the sub-module rfs_clear_counter (enable, clear, wrap flag); all else is in one module.

Verification (H_RES=4, V_RES=3 unless stated)
REQ-034 rst, frame_start, fb_ready=1 -> 12 writes (0,0)..(3,2), colour bk_color=3'b101, then lg_enable=1 on the following cycle.
REQ-035 fb_ready toggled 1,0,0,1 during CLEAR -> coordinates held through the low cycles, still exactly 12 accepted writes in raster order.
REQ-036 DRAW, lg_wr_req=1 at (2,1) colour 3'b011 with fb_ready=0 for 3 cycles -> no ack and fb_wr_en=1 held for 3 cycles, then ack and write in the cycle fb_ready rises.
REQ-037 RFS_CLIP_EN defined, lg request (4,0) -> lg_wr_ack=1, fb_wr_en=0 same cycle; undefined -> fb_wr_en=1 with fb_x=4.
REQ-038 raster_done, then vsync after 5 cycles -> buf_sel 0->1, one-cycle frame_done, IDLE; frame_start during DRAW -> CLEAR entered one cycle after IDLE.
REQ-039 rst asserted at clear write 6 -> next cycle fb_wr_en=0, busy=0, buf_sel=0; subsequent frame_start restarts clear at (0,0).
